noc_out_port_arbiter: RTL and testbench
=======================================

// Module: noc_out_port_arbiter
// PURPOSE
//  Round-robin arbiter plus one-flit output register for a single output port of a 4-port NoC mesh node.
//  Shares one output link among the node's four input ports (1..4); each input offers an addr/data flit.
//  Outputs: a valid/ack flit stream toward the neighbouring node (or a free edge wire).
//  One instance per output port; four per node; sits between the input ports and the mesh link.
// PARAMETERS
//  DATA_WIDTH     32  flit payload width
//  ADDRESS_WIDTH  5   destination node address width
//  CNT_WIDTH      16  width of forwarded-flit counter
// PORTS
//  clk           in   1              clock; all state updates on posedge
//  rst           in   1              synchronous, active-high reset
//  in_addr_1..4  in   ADDRESS_WIDTH  requester k destination address
//  in_data_1..4  in   DATA_WIDTH     requester k payload
//  in_valid_1..4 in   1              requester k holds a flit
//  to_in_ack_1..4 out 1              requester k flit captured at this edge (combinational)
//  out_addr      out  ADDRESS_WIDTH  held flit address
//  out_data      out  DATA_WIDTH     held flit payload
//  out_valid     out  1              held flit present
//  from_out_ack  in   1              downstream accepts held flit at this edge
//  rr_ptr        out  2              current highest-priority requester (0 = port 1)
//  flit_count    out  CNT_WIDTH      flits forwarded since reset
// BEHAVIOUR
//  Clock and reset: one clock domain (clk). rst is synchronous and active-high.
//  Reset values (rst=1 at edge): out_valid=0; out_addr=0; out_data=0; rr_ptr=0; flit_count=0.
//  During rst: to_in_ack_1..4 forced 0.
//  FSM has two states, encoded by out_valid:
//   EMPTY (out_valid=0): capture allowed (cap_en=1).
//   FULL  (out_valid=1): cap_en = from_out_ack (drain and refill at the same edge, no bubble).
//  Transitions:
//   EMPTY->FULL: any in_valid.
//   FULL->EMPTY: from_out_ack & no in_valid.
//   FULL->FULL: no ack (hold), or ack & any in_valid (refill).
//  Arbitration:
//   Search order starts at rr_ptr, then rr_ptr+1, ... mod 4.
//   The first requester with in_valid=1 is the winner g.
//   Grant only when cap_en=1 and rst=0.
//  Capture edge (grant):
//   to_in_ack_g=1 during that cycle (combinational from in_valid, rr_ptr, state, from_out_ack).
//   All other acks are 0; at most one ack is high per cycle.
//   out_addr/out_data <= in_addr_g/in_data_g; out_valid <= 1.
//   rr_ptr <= (g+1) mod 4; flit_count <= flit_count+1, wrapping from all-ones to 0.
//  No grant: rr_ptr and flit_count hold.
//  Latency: a flit presented in cycle N with the arbiter EMPTY appears on out_* in cycle N+1.
//  Throughput: 1 flit/cycle when from_out_ack is held high.
//  Hold rule: while out_valid=1 and from_out_ack=0, out_addr and out_data are stable and no ack is issued.
//  Source contract: a source holds in_valid, addr and data until it sees to_in_ack.
//   It may present a new flit in the cycle after the ack.
//   A source that drops in_valid without an ack is simply not granted.
//  from_out_ack while out_valid=0: ignored.
//  Reset mid-operation: the held flit is discarded without being counted again.
//   No ack is issued in the reset cycle. Normal operation resumes from EMPTY, rr_ptr=0.
// TESTING
//  T1 reset: rst=1 for 2 cycles with in_valid_1..4=1 -> all acks 0; out_valid=0; flit_count=0; rr_ptr=0.
//  T2 single flit: in_valid_1=1, addr=4, data=4 in cycle N (EMPTY) -> to_in_ack_1=1 in N.
//   Next cycle: out_valid=1, out_addr=4, out_data=4, flit_count=1, rr_ptr=1.
//  T3 backpressure: T2 then from_out_ack=0 for 5 cycles with in_valid_2=1 -> out_* stable 5 cycles, to_in_ack_2=0.
//   from_out_ack=1 -> same-edge capture of port 2.
//  T4 round robin: in_valid_1..4=1 continuously, from_out_ack=1 -> acks 1,2,3,4,1,2 on consecutive cycles.
//   flit_count increments by 1 each cycle.
//  T5 skip: rr_ptr=2, only in_valid_1=1 -> port 1 granted, rr_ptr becomes 1.
//  T6 wrap and reset: force flit_count=all-ones, capture one flit -> flit_count=0.
//   Then rst=1 while FULL -> out_valid=0 next cycle, rr_ptr=0.

Source files
------------

// File: rtl/noc_out_port_arbiter_if.sv
// Flit handshake bundle between the four input ports, the output-port
// arbiter and the downstream mesh link.
interface noc_out_port_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    // requester side: one addr/data/valid triple per input port, one ack back
    logic [ADDRESS_WIDTH-1:0] in_addr_1, in_addr_2, in_addr_3, in_addr_4;
    logic [DATA_WIDTH-1:0]    in_data_1, in_data_2, in_data_3, in_data_4;
    logic                     in_valid_1, in_valid_2, in_valid_3, in_valid_4;
    logic                     to_in_ack_1, to_in_ack_2, to_in_ack_3, to_in_ack_4;

    // link side: held flit and downstream accept
    logic [ADDRESS_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_valid;
    logic                     from_out_ack;

    // master: requesters plus downstream node (drives flits in, acks out)
    modport master (
        output in_addr_1, in_addr_2, in_addr_3, in_addr_4,
        output in_data_1, in_data_2, in_data_3, in_data_4,
        output in_valid_1, in_valid_2, in_valid_3, in_valid_4,
        input  to_in_ack_1, to_in_ack_2, to_in_ack_3, to_in_ack_4,
        input  out_addr, out_data, out_valid,
        output from_out_ack
    );

    // slave: the arbiter itself
    modport slave (
        input  in_addr_1, in_addr_2, in_addr_3, in_addr_4,
        input  in_data_1, in_data_2, in_data_3, in_data_4,
        input  in_valid_1, in_valid_2, in_valid_3, in_valid_4,
        output to_in_ack_1, to_in_ack_2, to_in_ack_3, to_in_ack_4,
        output out_addr, out_data, out_valid,
        input  from_out_ack
    );
endinterface

// File: rtl/noc_out_port_arbiter.sv
// Round-robin arbiter with a one-flit output register for one output port
// of a 4-port mesh node. A flit is captured whenever the register is empty
// or being drained at the same edge, so a held ack gives 1 flit/cycle.
module noc_out_port_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_out_port_arbiter_if.slave link,
    output logic [1:0]           rr_ptr,
    output logic [CNT_WIDTH-1:0] flit_count
);
    localparam int NUM_PORTS = 4;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [NUM_PORTS-1:0]     req_valid;
    logic [ADDRESS_WIDTH-1:0] req_addr [NUM_PORTS];
    logic [DATA_WIDTH-1:0]    req_data [NUM_PORTS];
    logic [NUM_PORTS-1:0]     ack_vec;
    logic [1:0]               win;
    logic [1:0]               scan_idx;
    logic                     any_req;
    logic                     cap_en;
    logic                     grant;

    logic [ADDRESS_WIDTH-1:0] out_addr_q;
    logic [DATA_WIDTH-1:0]    out_data_q;

    // gather the per-port requests into indexable arrays
    assign req_valid   = {link.in_valid_4, link.in_valid_3, link.in_valid_2, link.in_valid_1};
    assign req_addr[0] = link.in_addr_1;
    assign req_addr[1] = link.in_addr_2;
    assign req_addr[2] = link.in_addr_3;
    assign req_addr[3] = link.in_addr_4;
    assign req_data[0] = link.in_data_1;
    assign req_data[1] = link.in_data_2;
    assign req_data[2] = link.in_data_3;
    assign req_data[3] = link.in_data_4;

    // round-robin search: first valid requester starting at rr_ptr
    always_comb begin
        win      = 2'd0;
        any_req  = 1'b0;
        scan_idx = 2'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            scan_idx = rr_ptr + 2'(i);
            if (!any_req && req_valid[scan_idx]) begin
                any_req = 1'b1;
                win     = scan_idx;
            end
        end
    end

    // state register; reset discards any held flit
    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // next state, capture enable and the one-hot ack toward the winner
    always_comb begin
        state_d = state_q;
        cap_en  = 1'b0;
        case (state_q)
            EMPTY: begin
                cap_en = 1'b1;
                if (any_req) state_d = FULL;
            end
            FULL: begin
                // drain and refill at the same edge keeps the link bubble-free
                cap_en = link.from_out_ack;
                if (link.from_out_ack && !any_req) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        grant   = cap_en && any_req && !rst;
        ack_vec = grant ? (NUM_PORTS'(1) << win) : '0;
    end

    assign link.to_in_ack_1 = ack_vec[0];
    assign link.to_in_ack_2 = ack_vec[1];
    assign link.to_in_ack_3 = ack_vec[2];
    assign link.to_in_ack_4 = ack_vec[3];

    // flit register, priority pointer and forwarded-flit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_addr_q <= '0;
            out_data_q <= '0;
            rr_ptr     <= 2'd0;
            flit_count <= '0;
        end else if (grant) begin
            out_addr_q <= req_addr[win];
            out_data_q <= req_data[win];
            rr_ptr     <= win + 2'd1;
            flit_count <= flit_count + CNT_WIDTH'(1);
        end
    end

    assign link.out_addr  = out_addr_q;
    assign link.out_data  = out_data_q;
    assign link.out_valid = (state_q == FULL);
endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Scoreboard bench for the output-port arbiter: a reference model decides
// the expected grant each cycle, pushes the granted flit into a queue, and
// the held output flit is compared against the queue head until drained.
module tb_noc_out_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;   // small counter so the wrap is reachable

    logic clk = 1'b0;
    logic rst;
    logic [1:0]    rr_ptr;
    logic [CW-1:0] flit_count;

    always #5 clk = ~clk;

    noc_out_port_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    noc_out_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .link       (bus),
        .rr_ptr     (rr_ptr),
        .flit_count (flit_count)
    );

    // stimulus state
    logic [3:0]    v;
    logic [AW-1:0] a [4];
    logic [DW-1:0] d [4];
    logic          fack;

    assign bus.in_valid_1 = v[0];
    assign bus.in_valid_2 = v[1];
    assign bus.in_valid_3 = v[2];
    assign bus.in_valid_4 = v[3];
    assign bus.in_addr_1  = a[0];
    assign bus.in_addr_2  = a[1];
    assign bus.in_addr_3  = a[2];
    assign bus.in_addr_4  = a[3];
    assign bus.in_data_1  = d[0];
    assign bus.in_data_2  = d[1];
    assign bus.in_data_3  = d[2];
    assign bus.in_data_4  = d[3];
    assign bus.from_out_ack = fack;

    // reference model and scoreboard
    logic          m_full;
    int            m_rr;
    logic [CW-1:0] m_cnt;
    int            m_gnt;
    logic [3:0]    s_ack;
    logic [AW+DW-1:0] sb [$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // one clock: check outputs at negedge, advance the model, return just after posedge
    task automatic cycle();
        logic [3:0] e_ack;
        int p;
        @(negedge clk);
        e_ack = '0;
        m_gnt = -1;
        if (!rst && (!m_full || fack)) begin
            for (int i = 0; i < 4; i++) begin
                p = (m_rr + i) % 4;
                if (m_gnt < 0 && v[p]) m_gnt = p;
            end
        end
        if (m_gnt >= 0) e_ack[m_gnt] = 1'b1;
        s_ack = {bus.to_in_ack_4, bus.to_in_ack_3, bus.to_in_ack_2, bus.to_in_ack_1};
        chk("ack", 64'(s_ack), 64'(e_ack));
        chk("out_valid", 64'(bus.out_valid), 64'(m_full));
        chk("rr_ptr", 64'(rr_ptr), 64'(m_rr));
        chk("flit_count", 64'(flit_count), 64'(m_cnt));
        if (m_full) begin
            chk("sb_depth", 64'(sb.size()), 64'd1);
            if (sb.size() > 0) begin
                chk("flit", 64'({bus.out_addr, bus.out_data}), 64'(sb[0]));
                if (fack && !rst) void'(sb.pop_front());
            end
        end
        if (rst) begin
            m_full = 1'b0;
            m_rr   = 0;
            m_cnt  = '0;
            sb.delete();
        end else if (m_gnt >= 0) begin
            sb.push_back({a[m_gnt], d[m_gnt]});
            m_rr   = (m_gnt + 1) % 4;
            m_cnt  = m_cnt + 1'b1;
            m_full = 1'b1;
        end else if (m_full && fack) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_full = 1'b0;
        m_rr   = 0;
        m_cnt  = '0;
        m_gnt  = -1;
        s_ack  = '0;
        fack   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a[k] = AW'(k + 1);
            d[k] = DW'(32'h100 + k);
        end

        // T1: reset with every requester asserting
        rst = 1'b1;
        v   = 4'b1111;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;
        v   = 4'b0000;
        cycle();

        // T2: single flit from port 1 into an empty register
        v[0] = 1'b1; a[0] = 5'd4; d[0] = 32'd4;
        cycle();
        chk("t2_ack1", 64'(s_ack), 64'd1);
        v[0] = 1'b0;
        chk("t2_addr", 64'(bus.out_addr), 64'd4);
        chk("t2_data", 64'(bus.out_data), 64'd4);
        chk("t2_rr", 64'(rr_ptr), 64'd1);
        chk("t2_cnt", 64'(flit_count), 64'd1);

        // T3: backpressure for 5 cycles, then same-edge drain+capture of port 2
        v[1] = 1'b1; a[1] = 5'd7; d[1] = 32'h77;
        repeat (5) cycle();
        chk("t3_hold", 64'(bus.out_data), 64'd4);
        fack = 1'b1;
        cycle();
        chk("t3_ack2", 64'(s_ack), 64'd2);
        v[1] = 1'b0;
        chk("t3_data", 64'(bus.out_data), 64'h77);
        cycle();

        // T4: all ports requesting after reset -> 1,2,3,4,1,2
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        v = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t4_order", 64'(s_ack), 64'(4'b0001 << (i % 4)));
            chk("t4_cnt", 64'(flit_count), 64'(i + 1));
            if (m_gnt >= 0) d[m_gnt] = DW'($urandom);
        end
        v = 4'b0000;
        cycle();

        // T5: pointer at 2, only port 1 requesting -> skip to port 1
        v[1] = 1'b1;
        cycle();
        v[1] = 1'b0;
        cycle();
        chk("t5_rr_before", 64'(rr_ptr), 64'd2);
        v[0] = 1'b1; d[0] = 32'h5555;
        cycle();
        chk("t5_ack1", 64'(s_ack), 64'd1);
        v[0] = 1'b0;
        chk("t5_rr_after", 64'(rr_ptr), 64'd1);
        cycle();

        // random traffic honouring the hold-until-ack source contract
        for (int n = 0; n < 300; n++) begin
            fack = ($urandom_range(0, 3) != 0);
            cycle();
            for (int k = 0; k < 4; k++) begin
                if (m_gnt == k || !v[k]) begin
                    v[k] = ($urandom_range(0, 1) == 1);
                    a[k] = AW'($urandom);
                    d[k] = DW'($urandom);
                end
            end
        end
        v = 4'b0000;
        fack = 1'b1;
        cycle();
        cycle();

        // T6: counter wrap, then reset while FULL
        v[0] = 1'b1;
        for (int n = 0; n < 40 && m_cnt != {CW{1'b1}}; n++) begin
            cycle();
            d[0] = DW'($urandom);
        end
        chk("t6_pre_wrap", 64'(flit_count), 64'({CW{1'b1}}));
        cycle();
        chk("t6_wrap", 64'(flit_count), 64'd0);
        fack = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        v = 4'b0000;
        chk("t6_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rr", 64'(rr_ptr), 64'd0);
        chk("t6_cnt", 64'(flit_count), 64'd0);
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
